// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds one external full adder LSB-first for WIDTH
// cycles, chains its carry and collects the sum bits into Sum/Cout.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             fa_y,
    input  logic             fa_co,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] count;

    // Request handshake: start is accepted only on an edge where busy is low;
    // done pulses for one cycle when Sum/Cout become valid, and a start seen
    // while busy is dropped rather than queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            count <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= Cin;
                        count <= '0;
                        Sum   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    Sum   <= {fa_y, Sum[WIDTH-1:1]};
                    carry <= fa_co;
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        Cout  <= fa_co;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // The FA inputs are gated so the shared adder sees zeros outside RUN.
    always_comb begin
        fa_a  = 1'b0;
        fa_b  = 1'b0;
        fa_ci = 1'b0;
        if (state == RUN) begin
            fa_a  = a_sh[0];
            fa_b  = b_sh[0];
            fa_ci = carry;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 scenarios with a done-driven
// scoreboard, plus an exhaustive WIDTH=4 sweep, both with a behavioural FA.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] A, B;
    logic       Cin;
    logic       fa_y, fa_co, fa_a, fa_b, fa_ci;
    logic       busy, done, Cout;
    logic [7:0] Sum;
    logic [1:0] state_dbg;

    logic       start4;
    logic [3:0] a4, b4;
    logic       cin4;
    logic       fa_y4, fa_co4, fa_a4, fa_b4, fa_ci4;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;
    logic [1:0] state_dbg4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] exp_q[$];
    logic [4:0] exp4_q[$];

    always #5 clk = ~clk;

    assign fa_y   = fa_a ^ fa_b ^ fa_ci;
    assign fa_co  = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);
    assign fa_y4  = fa_a4 ^ fa_b4 ^ fa_ci4;
    assign fa_co4 = (fa_a4 & fa_b4) | (fa_a4 & fa_ci4) | (fa_b4 & fa_ci4);

    serial_add_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .Cin(Cin),
        .fa_y(fa_y), .fa_co(fa_co), .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci),
        .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .state_dbg(state_dbg)
    );

    serial_add_ctrl #(.WIDTH(4), .CNT_W(2)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .A(a4), .B(b4), .Cin(cin4),
        .fa_y(fa_y4), .fa_co(fa_co4), .fa_a(fa_a4), .fa_b(fa_b4), .fa_ci(fa_ci4),
        .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4), .state_dbg(state_dbg4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check("done_has_expectation", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("sum_cout", 32'({Cout, Sum}), 32'(exp_q.pop_front()));
        end
    end

    // Drives one operation from a negedge and follows it until busy drops.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         output int lat, output int busy_n, output logic [7:0] ci_tr);
        A = a; B = b; Cin = ci; start = 1'b1;
        exp_q.push_back(9'(a) + 9'(b) + 9'(ci));
        lat = -1; busy_n = 0; ci_tr = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
            if (c < 8) ci_tr[c] = fa_ci;
            if (done && lat < 0) lat = c;
            if (c >= 8) check("fa_zero_outside_run", 32'({fa_a, fa_b, fa_ci}), 32'd0);
            if (!busy) break;
        end
    endtask

    initial begin
        int lat, busy_n, dones;
        logic [7:0] ci_tr;

        reset = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        @(negedge clk); @(negedge clk);
        check("reset_state", 32'(state_dbg), 32'd0);
        check("reset_outputs", 32'({busy, done, Cout, Sum, fa_a, fa_b, fa_ci}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Zero operands: latency, busy length, quiet FA outside RUN.
        check("idle_fa_zero", 32'({fa_a, fa_b, fa_ci}), 32'd0);
        do_op(8'h00, 8'h00, 1'b0, lat, busy_n, ci_tr);
        check("latency_zero_op", 32'(lat), 32'd8);
        check("busy_cycles", 32'(busy_n), 32'd9);

        // Carry ripple through every bit.
        do_op(8'hFF, 8'h01, 1'b0, lat, busy_n, ci_tr);
        check("fa_ci_trace", 32'(ci_tr), 32'hFE);
        check("latency_ff01", 32'(lat), 32'd8);

        // Two operations back-to-back, second start at E10.
        do_op(8'hA5, 8'h5A, 1'b1, lat, busy_n, ci_tr);
        check("a55a_held_idle", 32'({Cout, Sum}), 32'h100);
        do_op(8'h3C, 8'h0F, 1'b0, lat, busy_n, ci_tr);
        check("latency_b2b", 32'(lat), 32'd8);

        // Operand churn plus starts during RUN and DONE.
        A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h046);
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            A = 8'($urandom_range(0, 255)); B = 8'($urandom_range(0, 255));
            Cin = 1'($urandom_range(0, 1));
            start = (c == 2 || c == 8);
            if (done) dones++;
        end
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("single_done_pulse", 32'(dones), 32'd1);
        check("ignored_start_idle", 32'(busy), 32'd0);
        check("held_result_1234", 32'({Cout, Sum}), 32'h046);

        // Reset in the middle of RUN aborts without a done pulse.
        A = 8'hF0; B = 8'h0F; Cin = 1'b0; start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 3) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_result", 32'({busy, Cout, Sum}), 32'd0);
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        do_op(8'h01, 8'h01, 1'b0, lat, busy_n, ci_tr);
        check("latency_after_abort", 32'(lat), 32'd8);

        // Exhaustive WIDTH=4 sweep.
        for (int v = 0; v < 512; v++) begin
            logic [4:0] got;
            logic [4:0] want;
            bit seen;
            a4 = 4'(v >> 5); b4 = 4'(v >> 1); cin4 = 1'(v);
            exp4_q.push_back(5'(a4) + 5'(b4) + 5'(cin4));
            start4 = 1'b1;
            seen = 1'b0;
            got = '0;
            for (int c = 0; c < 20 && busy4 !== 1'b0 || c == 0; c++) begin
                @(negedge clk);
                start4 = 1'b0;
                if (done4 && !seen) begin
                    seen = 1'b1;
                    got = {cout4, sum4};
                end
            end
            check("w4_done_seen", 32'(seen), 32'd1);
            want = exp4_q.pop_front();
            check("w4_sum", 32'(got), 32'(want));
            if (got === want) $write(".");
            if (v % 64 == 63) $write("\n");
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
